spi_fl_sequencer: RTL and testbench

Command sequencer between the CPU-side flash request port and the `spi_master_fl` SPI flash master. It turns one high-level request (read word, read ID, program word, sector erase) into the ordered list of single SPI commands the flash needs. Those commands are write-enable, the operation itself, and status polling until write-in-progress clears. It also handles the master's validflag/tready/validflag_out handshake, including clock-domain slack, and reports timeouts.

---
 rtl/spi_fl_pkg.sv | 37 +++
 rtl/spi_fl_cmd_issuer.sv | 110 +++++++++++
 rtl/spi_fl_sequencer.sv | 151 +++++++++++++++
 tb/tb_spi_fl_sequencer.sv | 326 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_fl_pkg.sv
// spi_fl_pkg: opcodes, commtypes, request op codes and bus widths shared
// by the SPI flash command sequencer and its command issuer.
package spi_fl_pkg;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 24;
    localparam int CMD_W  = 8;
    localparam int CT_W   = 3;

    localparam logic [CMD_W-1:0] FL_READ = 8'h03;
    localparam logic [CMD_W-1:0] FL_RDID = 8'h9F;
    localparam logic [CMD_W-1:0] FL_WREN = 8'h06;
    localparam logic [CMD_W-1:0] FL_PP   = 8'h02;
    localparam logic [CMD_W-1:0] FL_SE   = 8'h20;
    localparam logic [CMD_W-1:0] FL_RDSR = 8'h05;

    localparam logic [CT_W-1:0] CT_CMD           = 3'b000;
    localparam logic [CT_W-1:0] CT_CMD_ANS       = 3'b001;
    localparam logic [CT_W-1:0] CT_CMD_ADDR_ANS  = 3'b010;
    localparam logic [CT_W-1:0] CT_CMD_DATA      = 3'b011;
    localparam logic [CT_W-1:0] CT_CMD_ADDR_DATA = 3'b100;
    localparam logic [CT_W-1:0] CT_CMD_ADDR      = 3'b101;
    localparam logic [CT_W-1:0] CT_IDLE          = 3'b111;

    typedef enum logic [1:0] {
        OP_READ    = 2'd0,
        OP_READ_ID = 2'd1,
        OP_PROGRAM = 2'd2,
        OP_ERASE   = 2'd3
    } fl_op_e;

    // Commtypes for which the master returns an answer word.
    function automatic logic ct_has_ans(input logic [CT_W-1:0] ct);
        return (ct == CT_CMD_ANS) || (ct == CT_CMD_ADDR_ANS);
    endfunction

endpackage

// File: rtl/spi_fl_cmd_issuer.sv
// spi_fl_cmd_issuer: runs one command through the master handshake
// (validflag / tready / validflag_out) with ack timeout and answer capture.
// Ports: start/cmd/commtype/addr/data in; done/err/ans out; m_* to master.
module spi_fl_cmd_issuer
    import spi_fl_pkg::*;
#(
    parameter int ACK_TIMEOUT = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [CMD_W-1:0]  cmd,
    input  logic [CT_W-1:0]   commtype,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] data,
    output logic              done,
    output logic              err,
    output logic [DATA_W-1:0] ans,
    output logic [DATA_W-1:0] m_data_in,
    output logic [ADDR_W-1:0] m_address,
    output logic [CMD_W-1:0]  m_command,
    output logic [CT_W-1:0]   m_commtype,
    output logic              m_valid,
    input  logic [DATA_W-1:0] m_data_out,
    input  logic              m_valid_out,
    input  logic              m_tready
);

    localparam int AW = $clog2(ACK_TIMEOUT) + 1;

    typedef enum logic [1:0] {I_IDLE, I_SEND, I_ACK, I_FIN} istate_e;

    istate_e       state, state_n;
    logic [AW-1:0] ack_cnt;
    logic          ans_seen;
    logic          load;

    always_comb begin
        state_n = state;
        load    = 1'b0;
        m_valid = 1'b0;
        done    = 1'b0;
        err     = 1'b0;
        unique case (state)
            I_IDLE: begin
                if (start && m_tready) begin
                    load    = 1'b1;
                    state_n = I_SEND;
                end
            end
            // Gated by tready so a late tready drop never sees validflag.
            I_SEND: begin
                if (m_tready) begin
                    m_valid = 1'b1;
                    state_n = I_ACK;
                end
            end
            I_ACK: begin
                if (!m_tready) begin
                    state_n = I_FIN;
                end else if (ack_cnt == AW'(ACK_TIMEOUT - 1)) begin
                    err     = 1'b1;
                    state_n = I_IDLE;
                end
            end
            I_FIN: begin
                if (m_tready && (ans_seen || !ct_has_ans(m_commtype))) begin
                    done    = 1'b1;
                    state_n = I_IDLE;
                end
            end
            default: state_n = I_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= I_IDLE;
            ack_cnt    <= '0;
            ans_seen   <= 1'b0;
            ans        <= '0;
            m_data_in  <= '0;
            m_address  <= '0;
            m_command  <= '0;
            m_commtype <= CT_IDLE;
        end else begin
            state <= state_n;
            if (load) begin
                m_command  <= cmd;
                m_commtype <= commtype;
                m_address  <= addr;
                m_data_in  <= data;
            end else if (done || err) begin
                m_commtype <= CT_IDLE;
            end
            if (state == I_SEND) begin
                ack_cnt  <= '0;
                ans_seen <= 1'b0;
            end else if (state == I_ACK && m_tready) begin
                ack_cnt <= ack_cnt + 1'b1;
            end
            // Answer may arrive while tready is still low; keep it sticky.
            if ((state == I_ACK || state == I_FIN) && m_valid_out) begin
                ans_seen <= 1'b1;
                ans      <= m_data_out;
            end
        end
    end

endmodule

// File: rtl/spi_fl_sequencer.sv
// spi_fl_sequencer: expands READ / READ_ID / PROGRAM / ERASE requests into
// WREN, op and status-poll commands for the spi_fl master.
// Ports: req_*/resp_* CPU side, busy, m_* to/from spi_master_fl.
module spi_fl_sequencer
    import spi_fl_pkg::*;
#(
    parameter int POLL_MAX    = 1024,
    parameter int ACK_TIMEOUT = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [1:0]        req_op,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              resp_valid,
    output logic [DATA_W-1:0] resp_rdata,
    output logic              resp_err,
    output logic              busy,
    output logic [DATA_W-1:0] m_data_in,
    output logic [ADDR_W-1:0] m_address,
    output logic [CMD_W-1:0]  m_command,
    output logic [CT_W-1:0]   m_commtype,
    output logic              m_valid,
    input  logic [DATA_W-1:0] m_data_out,
    input  logic              m_valid_out,
    input  logic              m_tready
);

    localparam int PW = $clog2(POLL_MAX) + 1;

    typedef enum logic [2:0] {S_IDLE, S_WREN, S_OPCMD, S_POLL, S_RESP} state_e;

    state_e            state, state_n;
    fl_op_e            op_r;
    logic [ADDR_W-1:0] addr_r;
    logic [DATA_W-1:0] wdata_r;
    logic [PW-1:0]     poll_cnt;
    logic              err_r;

    logic              iss_start, iss_done, iss_err;
    logic [DATA_W-1:0] iss_ans;
    logic [CMD_W-1:0]  cmd;
    logic [CT_W-1:0]   ct;

    logic is_wr, req_is_wr, wip, poll_last;

    assign is_wr     = (op_r == OP_PROGRAM) || (op_r == OP_ERASE);
    assign req_is_wr = (fl_op_e'(req_op) == OP_PROGRAM) ||
                       (fl_op_e'(req_op) == OP_ERASE);
    assign wip       = iss_ans[24];
    assign poll_last = (poll_cnt == PW'(POLL_MAX - 1));

    assign req_ready  = (state == S_IDLE);
    assign busy       = (state != S_IDLE);
    assign resp_valid = (state == S_RESP);
    assign resp_err   = (state == S_RESP) && err_r;

    always_comb begin
        state_n   = state;
        iss_start = 1'b0;
        cmd       = FL_RDSR;
        ct        = CT_CMD_ANS;
        unique case (state)
            S_IDLE: begin
                if (req_valid) state_n = req_is_wr ? S_WREN : S_OPCMD;
            end
            S_WREN: begin
                iss_start = 1'b1;
                cmd       = FL_WREN;
                ct        = CT_CMD;
                if (iss_err)       state_n = S_RESP;
                else if (iss_done) state_n = S_OPCMD;
            end
            S_OPCMD: begin
                iss_start = 1'b1;
                unique case (op_r)
                    OP_READ:    begin cmd = FL_READ; ct = CT_CMD_ADDR_ANS;  end
                    OP_READ_ID: begin cmd = FL_RDID; ct = CT_CMD_ANS;       end
                    OP_PROGRAM: begin cmd = FL_PP;   ct = CT_CMD_ADDR_DATA; end
                    OP_ERASE:   begin cmd = FL_SE;   ct = CT_CMD_ADDR;      end
                    default:    begin cmd = FL_READ; ct = CT_CMD_ADDR_ANS;  end
                endcase
                if (iss_err)       state_n = S_RESP;
                else if (iss_done) state_n = is_wr ? S_POLL : S_RESP;
            end
            S_POLL: begin
                iss_start = 1'b1;
                if (iss_err) state_n = S_RESP;
                else if (iss_done && (!wip || poll_last)) state_n = S_RESP;
            end
            S_RESP:  state_n = S_IDLE;
            default: state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= S_IDLE;
            op_r       <= OP_READ;
            addr_r     <= '0;
            wdata_r    <= '0;
            poll_cnt   <= '0;
            err_r      <= 1'b0;
            resp_rdata <= '0;
        end else begin
            state <= state_n;
            if (state == S_IDLE && req_valid) begin
                op_r     <= fl_op_e'(req_op);
                addr_r   <= req_addr;
                wdata_r  <= req_wdata;
                poll_cnt <= '0;
                err_r    <= 1'b0;
            end
            if (iss_err) err_r <= 1'b1;
            if (iss_done && state == S_OPCMD && !is_wr) begin
                resp_rdata <= iss_ans;
            end
            if (iss_done && state == S_POLL) begin
                resp_rdata <= iss_ans;
                if (wip && poll_last) err_r <= 1'b1;
                if (wip && !poll_last) poll_cnt <= poll_cnt + 1'b1;
            end
        end
    end

    spi_fl_cmd_issuer #(
        .ACK_TIMEOUT (ACK_TIMEOUT)
    ) u_issuer (
        .clk         (clk),
        .rst         (rst),
        .start       (iss_start),
        .cmd         (cmd),
        .commtype    (ct),
        .addr        (addr_r),
        .data        (wdata_r),
        .done        (iss_done),
        .err         (iss_err),
        .ans         (iss_ans),
        .m_data_in   (m_data_in),
        .m_address   (m_address),
        .m_command   (m_command),
        .m_commtype  (m_commtype),
        .m_valid     (m_valid),
        .m_data_out  (m_data_out),
        .m_valid_out (m_valid_out),
        .m_tready    (m_tready)
    );

endmodule

// File: tb/tb_spi_fl_sequencer.sv
// tb_spi_fl_sequencer: random and directed requests against a behavioural
// flash master and a command-list reference model.
module tb_spi_fl_sequencer;
    import spi_fl_pkg::*;

    localparam int POLL_MAX    = 4;
    localparam int ACK_TIMEOUT = 16;
    localparam int WAIT_MAX    = 2000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic [1:0]  req_op = 2'd0;
    logic [23:0] req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic        req_ready, resp_valid, resp_err, busy, m_valid;
    logic [31:0] resp_rdata, m_data_in;
    logic [23:0] m_address;
    logic [7:0]  m_command;
    logic [2:0]  m_commtype;
    logic [31:0] m_data_out;
    logic        m_valid_out, m_tready;

    always #5 clk = ~clk;

    spi_fl_sequencer #(
        .POLL_MAX    (POLL_MAX),
        .ACK_TIMEOUT (ACK_TIMEOUT)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_op      (req_op),
        .req_addr    (req_addr),
        .req_wdata   (req_wdata),
        .resp_valid  (resp_valid),
        .resp_rdata  (resp_rdata),
        .resp_err    (resp_err),
        .busy        (busy),
        .m_data_in   (m_data_in),
        .m_address   (m_address),
        .m_command   (m_command),
        .m_commtype  (m_commtype),
        .m_valid     (m_valid),
        .m_data_out  (m_data_out),
        .m_valid_out (m_valid_out),
        .m_tready    (m_tready)
    );

    typedef struct packed {
        logic [7:0]  cmd;
        logic [2:0]  ct;
        logic [23:0] addr;
        logic [31:0] data;
    } cmd_t;

    typedef enum {M_NORMAL, M_STUCK, M_EARLY} mmode_e;

    int          checks = 0;
    int          failures = 0;
    int          n_done = 0;
    int          resp_cnt = 0;
    mmode_e      mmode = M_NORMAL;
    logic [31:0] stat_q[$];
    logic [31:0] stat_dflt = '0;
    logic [31:0] rd_ans = '0;
    cmd_t        log_q[$];
    cmd_t        exp_q[$];
    logic        m_busy = 1'b0;
    logic        mv_prev = 1'b0;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    // Flash master: drops tready after each validflag, answers
    // RDSR from stat_q and READ/RDID with rd_ans.
    initial begin
        cmd_t        e;
        logic [31:0] a;
        logic        need, sent;
        m_tready    = 1'b1;
        m_valid_out = 1'b0;
        m_data_out  = '0;
        forever begin
            @(negedge clk);
            if (m_valid === 1'b1) begin
                e.cmd  = m_command;
                e.ct   = m_commtype;
                e.addr = m_address;
                e.data = m_data_in;
                log_q.push_back(e);
                if (mmode != M_STUCK) begin
                    m_busy = 1'b1;
                    need = (m_commtype == 3'b001) || (m_commtype == 3'b010);
                    if (m_command == 8'h05)
                        a = (stat_q.size() > 0) ? stat_q.pop_front() : stat_dflt;
                    else
                        a = rd_ans;
                    sent = 1'b0;
                    repeat ($urandom_range(1, 3)) @(negedge clk);
                    m_tready = 1'b0;
                    repeat ($urandom_range(1, 4)) @(negedge clk);
                    if (need && (mmode == M_EARLY || $urandom_range(0, 1) == 1)) begin
                        m_valid_out = 1'b1;
                        m_data_out  = a;
                        @(negedge clk);
                        m_valid_out = 1'b0;
                        sent = 1'b1;
                    end
                    m_tready = 1'b1;
                    if (need && !sent) begin
                        repeat ($urandom_range(0, 2)) @(negedge clk);
                        m_valid_out = 1'b1;
                        m_data_out  = a;
                        @(negedge clk);
                        m_valid_out = 1'b0;
                    end
                    m_busy = 1'b0;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (m_valid === 1'b1) begin
            chk("mvalid_tready", 32'(m_tready), 1);
            chk("mvalid_single", 32'(mv_prev), 0);
        end
        mv_prev = m_valid;
        if (resp_valid === 1'b1) resp_cnt++;
    end

    // Expected command list and response, from the request rules.
    task automatic model(input logic [1:0] op, input logic [23:0] a,
                         input logic [31:0] d, output logic [31:0] er,
                         output logic ee);
        logic [31:0] st[$];
        logic [31:0] s;
        st = stat_q;
        er = '0;
        ee = 1'b0;
        exp_q.delete();
        case (op)
            2'd0: begin
                exp_q.push_back({8'h03, 3'b010, a, 32'h0});
                er = rd_ans;
            end
            2'd1: begin
                exp_q.push_back({8'h9F, 3'b001, 24'h0, 32'h0});
                er = rd_ans;
            end
            default: begin
                exp_q.push_back({8'h06, 3'b000, 24'h0, 32'h0});
                if (op == 2'd2) exp_q.push_back({8'h02, 3'b100, a, d});
                else            exp_q.push_back({8'h20, 3'b101, a, 32'h0});
                for (int i = 0; i < POLL_MAX; i++) begin
                    s = (st.size() > 0) ? st.pop_front() : stat_dflt;
                    exp_q.push_back({8'h05, 3'b001, 24'h0, 32'h0});
                    er = s;
                    if (!s[24]) break;
                    if (i == POLL_MAX - 1) ee = 1'b1;
                end
            end
        endcase
    endtask

    task automatic run_txn(input logic [1:0] op, input logic [23:0] a,
                           input logic [31:0] d, input logic to_exp);
        logic [31:0] er, rdata;
        logic        ee, err, got;
        int          lat, n;
        model(op, a, d, er, ee);
        if (to_exp) ee = 1'b1;
        @(negedge clk);
        chk("req_ready", 32'(req_ready), 1);
        log_q.delete();
        req_valid = 1'b1;
        req_op    = op;
        req_addr  = a;
        req_wdata = d;
        @(negedge clk);
        req_op   = 2'($urandom);
        req_addr = 24'($urandom);
        got = 1'b0;
        err = 1'b0;
        rdata = '0;
        lat = 0;
        for (int i = 0; i < WAIT_MAX; i++) begin
            if (resp_valid) begin
                got   = 1'b1;
                rdata = resp_rdata;
                err   = resp_err;
                lat   = i;
                break;
            end
            req_valid = 1'($urandom_range(0, 1));
            @(negedge clk);
        end
        req_valid = 1'b0;
        chk("resp_seen", 32'(got), 1);
        if (got) begin
            n_done++;
            chk("resp_err", 32'(err), 32'(ee));
            if (!to_exp) chk("resp_rdata", rdata, er);
            else         chk("timeout_latency", 32'(lat >= ACK_TIMEOUT), 1);
            @(negedge clk);
            chk("resp_one_cycle", 32'(resp_valid), 0);
            chk("ready_after", 32'(req_ready), 1);
            chk("busy_after", 32'(busy), 0);
        end
        chk("n_cmds", 32'(log_q.size()), 32'(exp_q.size()));
        n = (log_q.size() < exp_q.size()) ? log_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) begin
            chk("cmd", 32'(log_q[i].cmd), 32'(exp_q[i].cmd));
            chk("commtype", 32'(log_q[i].ct), 32'(exp_q[i].ct));
            if (exp_q[i].ct inside {3'b010, 3'b100, 3'b101})
                chk("addr", 32'(log_q[i].addr), 32'(exp_q[i].addr));
            if (exp_q[i].ct == 3'b100)
                chk("wdata", log_q[i].data, exp_q[i].data);
        end
    endtask

    task automatic chk_reset(input string p);
        chk({p, "req_ready"}, 32'(req_ready), 1);
        chk({p, "busy"}, 32'(busy), 0);
        chk({p, "resp_valid"}, 32'(resp_valid), 0);
        chk({p, "resp_err"}, 32'(resp_err), 0);
        chk({p, "m_valid"}, 32'(m_valid), 0);
        chk({p, "resp_rdata"}, resp_rdata, 0);
        chk({p, "m_data_in"}, m_data_in, 0);
        chk({p, "m_address"}, 32'(m_address), 0);
        chk({p, "m_command"}, 32'(m_command), 0);
        chk({p, "m_commtype"}, 32'(m_commtype), 7);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int          nrd, rc, k;
        logic [31:0] wd;
        repeat (2) @(negedge clk);
        chk_reset("rst_");
        rst = 1'b0;

        rd_ans = 32'hDEADBEEF;
        run_txn(2'd0, 24'h001000, 32'h0, 1'b0);

        stat_q.delete();
        stat_q.push_back(32'h0103_0000);
        stat_q.push_back(32'h01FF_1234);
        stat_q.push_back(32'h0100_0001);
        stat_q.push_back(32'h0002_0000);
        run_txn(2'd2, 24'h000100, 32'h12345678, 1'b0);

        stat_q.delete();
        stat_dflt = 32'h01FF_0000;
        run_txn(2'd3, 24'h020000, 32'h0, 1'b0);
        stat_dflt = 32'h0;

        mmode = M_STUCK;
        rd_ans = 32'h0BAD_0BAD;
        run_txn(2'd0, 24'h000040, 32'h0, 1'b1);
        mmode = M_NORMAL;

        mmode = M_EARLY;
        rd_ans = 32'h00EF4018;
        run_txn(2'd1, 24'h0, 32'h0, 1'b0);
        mmode = M_NORMAL;

        stat_q.delete();
        repeat (6) stat_q.push_back(32'h0100_0000 | 32'($urandom_range(0, 255)));
        @(negedge clk);
        log_q.delete();
        req_valid = 1'b1;
        req_op    = 2'd2;
        req_addr  = 24'h000200;
        req_wdata = 32'hA5A5_5A5A;
        @(negedge clk);
        req_valid = 1'b0;
        nrd = 0;
        for (int i = 0; i < WAIT_MAX && nrd < 2; i++) begin
            @(negedge clk);
            nrd = 0;
            foreach (log_q[j]) if (log_q[j].cmd == 8'h05) nrd++;
        end
        chk("poll_reached", 32'(nrd >= 2), 1);
        rc = resp_cnt;
        #2 rst = 1'b1;
        #1 chk_reset("mid_");
        repeat (3) @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < WAIT_MAX && m_busy; i++) @(negedge clk);
        chk("no_resp_on_abort", 32'(resp_cnt), 32'(rc));
        stat_q.delete();
        rd_ans = $urandom;
        run_txn(2'd0, 24'h00ABCD, 32'h0, 1'b0);

        for (int t = 0; t < 24; t++) begin
            rd_ans = $urandom;
            wd = $urandom;
            stat_q.delete();
            k = $urandom_range(0, 5);
            for (int j = 0; j < k; j++)
                stat_q.push_back($urandom | 32'h0100_0000);
            stat_q.push_back($urandom & ~32'h0100_0000);
            run_txn(2'($urandom_range(0, 3)), 24'($urandom), wd, 1'b0);
        end

        repeat (3) @(negedge clk);
        chk("resp_count", 32'(resp_cnt), 32'(n_done));
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
